// File: rtl/fade_if.sv
// Control and status bundle between the fade sequencer and its consumers.
// The slave side is the sequencer; the master side drives en/hold.
interface fade_if #(
  parameter int unsigned DW = 11
);
  logic          en;
  logic          hold;
  logic [DW-1:0] pwm_cnt;
  logic          period_end;
  logic [DW-1:0] duty_r;
  logic [DW-1:0] duty_g;
  logic [DW-1:0] duty_b;
  logic [2:0]    phase;
  logic          phase_done;

  modport master (
    output en, hold,
    input  pwm_cnt, period_end, duty_r, duty_g, duty_b, phase, phase_done
  );

  modport slave (
    input  en, hold,
    output pwm_cnt, period_end, duty_r, duty_g, duty_b, phase, phase_done
  );
endinterface

// File: rtl/fade_sequencer.sv
// Colour-wheel controller: owns the PWM period counter and walks R/G/B duties
// through a 6-phase hue cycle, updating duties only on period boundaries.
module fade_sequencer #(
  parameter int unsigned PWM_INTERVAL     = 1200,
  parameter int unsigned PERIODS_PER_STEP = 10,
  parameter int unsigned DUTY_STEP        = 12
) (
  input logic   clk,
  input logic   rst,
  fade_if.slave fade_io
);

  localparam int unsigned DW = $clog2(PWM_INTERVAL + 1);
  localparam int unsigned SW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;

  localparam logic [DW-1:0] DUTY_MAX = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] CNT_LAST = DW'(PWM_INTERVAL - 1);
  localparam logic [DW:0]   STEP_W   = (DW+1)'(DUTY_STEP);
  localparam logic [SW-1:0] STEP_LAST = SW'(PERIODS_PER_STEP - 1);

  // Phase encoding: which channel moves and in which direction.
  localparam logic [2:0] PH_G_UP = 3'd0;
  localparam logic [2:0] PH_R_DN = 3'd1;
  localparam logic [2:0] PH_B_UP = 3'd2;
  localparam logic [2:0] PH_G_DN = 3'd3;
  localparam logic [2:0] PH_R_UP = 3'd4;
  localparam logic [2:0] PH_B_DN = 3'd5;

  logic [DW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [DW-1:0] duty_r_q, duty_r_d;
  logic [DW-1:0] duty_g_q, duty_g_d;
  logic [DW-1:0] duty_b_q, duty_b_d;
  logic [2:0]    phase_q, phase_d;
  logic          phase_done_q, phase_done_d;

  logic          period_end_c;
  logic          step_adv_c;
  logic          step_evt_c;
  logic          rising_c;
  logic [DW-1:0] cur_c;
  logic [DW-1:0] upd_c;
  logic          hit_c;
  logic [DW:0]   calc_c;
  logic [2:0]    phase_nxt_c;

  assign period_end_c = fade_io.en && (pwm_cnt_q == CNT_LAST);
  assign step_adv_c   = period_end_c && !fade_io.hold;
  assign step_evt_c   = step_adv_c && (step_cnt_q == STEP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q    <= '0;
      step_cnt_q   <= '0;
      duty_r_q     <= DUTY_MAX;
      duty_g_q     <= '0;
      duty_b_q     <= '0;
      phase_q      <= PH_G_UP;
      phase_done_q <= 1'b0;
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      step_cnt_q   <= step_cnt_d;
      duty_r_q     <= duty_r_d;
      duty_g_q     <= duty_g_d;
      duty_b_q     <= duty_b_d;
      phase_q      <= phase_d;
      phase_done_q <= phase_done_d;
    end
  end

  // Select the moving channel, compute its saturated next value, then commit on a step.
  always_comb begin
    pwm_cnt_d    = pwm_cnt_q;
    step_cnt_d   = step_cnt_q;
    duty_r_d     = duty_r_q;
    duty_g_d     = duty_g_q;
    duty_b_d     = duty_b_q;
    phase_d      = phase_q;
    phase_done_d = 1'b0;
    rising_c     = 1'b0;
    cur_c        = '0;
    upd_c        = '0;
    hit_c        = 1'b0;
    calc_c       = '0;
    phase_nxt_c  = PH_G_UP;

    if (fade_io.en) begin
      pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + DW'(1);
    end

    if (step_adv_c) begin
      step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + SW'(1);
    end

    case (phase_q)
      PH_G_UP: begin cur_c = duty_g_q; rising_c = 1'b1; phase_nxt_c = PH_R_DN; end
      PH_R_DN: begin cur_c = duty_r_q; rising_c = 1'b0; phase_nxt_c = PH_B_UP; end
      PH_B_UP: begin cur_c = duty_b_q; rising_c = 1'b1; phase_nxt_c = PH_G_DN; end
      PH_G_DN: begin cur_c = duty_g_q; rising_c = 1'b0; phase_nxt_c = PH_R_UP; end
      PH_R_UP: begin cur_c = duty_r_q; rising_c = 1'b1; phase_nxt_c = PH_B_DN; end
      PH_B_DN: begin cur_c = duty_b_q; rising_c = 1'b0; phase_nxt_c = PH_G_UP; end
      default: begin cur_c = '0;       rising_c = 1'b0; phase_nxt_c = PH_G_UP; end
    endcase

    // Extra bit keeps the add/subtract from wrapping before saturation.
    if (rising_c) begin
      calc_c = {1'b0, cur_c} + STEP_W;
      if (calc_c >= {1'b0, DUTY_MAX}) begin
        upd_c = DUTY_MAX;
        hit_c = 1'b1;
      end else begin
        upd_c = calc_c[DW-1:0];
      end
    end else begin
      calc_c = {1'b0, cur_c} - STEP_W;
      if (calc_c[DW] || (calc_c == '0)) begin
        upd_c = '0;
        hit_c = 1'b1;
      end else begin
        upd_c = calc_c[DW-1:0];
      end
    end

    if (step_evt_c) begin
      case (phase_q)
        PH_G_UP, PH_G_DN: duty_g_d = upd_c;
        PH_R_DN, PH_R_UP: duty_r_d = upd_c;
        PH_B_UP, PH_B_DN: duty_b_d = upd_c;
        default:          duty_r_d = duty_r_q;
      endcase
      if (hit_c) begin
        phase_d      = phase_nxt_c;
        phase_done_d = 1'b1;
      end
    end

    // Unused encodings fall back to the start of the wheel.
    if (phase_q > PH_B_DN) begin
      phase_d = PH_G_UP;
    end
  end

  assign fade_io.pwm_cnt    = pwm_cnt_q;
  assign fade_io.period_end = period_end_c;
  assign fade_io.duty_r     = duty_r_q;
  assign fade_io.duty_g     = duty_g_q;
  assign fade_io.duty_b     = duty_b_q;
  assign fade_io.phase      = phase_q;
  assign fade_io.phase_done = phase_done_q;

endmodule

// File: tb/tb_fade_sequencer.sv
// Directed bench for fade_sequencer at PWM_INTERVAL=12, PERIODS_PER_STEP=2, DUTY_STEP=4.
module tb_fade_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fade_if #(.DW(4)) fade_bus ();

  fade_sequencer #(
    .PWM_INTERVAL     (12),
    .PERIODS_PER_STEP (2),
    .DUTY_STEP        (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .fade_io (fade_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bench always sits on a negedge; n negedges later n posedges have passed.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fade_bus.en   = 1'b0;
    fade_bus.hold = 1'b0;
    tick(2);
    rst = 1'b0;
    fade_bus.en = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pwm"},   int'(fade_bus.pwm_cnt), 0);
    check({tag, "_pend"},  int'(fade_bus.period_end), 0);
    check({tag, "_r"},     int'(fade_bus.duty_r), 12);
    check({tag, "_g"},     int'(fade_bus.duty_g), 0);
    check({tag, "_b"},     int'(fade_bus.duty_b), 0);
    check({tag, "_phase"}, int'(fade_bus.phase), 0);
    check({tag, "_pdone"}, int'(fade_bus.phase_done), 0);
  endtask

  initial begin
    int pulses;
    int glitches;
    int overs;
    int pr, pg, pb;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    fade_bus.en   = 1'b0;
    fade_bus.hold = 1'b0;

    // 1: first steps and first phase transition
    do_reset();
    check_reset_state("rst0");
    tick(11);
    check("t1_pwm11", int'(fade_bus.pwm_cnt), 11);
    check("t1_pend11", int'(fade_bus.period_end), 1);
    tick(1);
    check("t1_pend12", int'(fade_bus.period_end), 0);
    tick(11);
    check("t1_g23", int'(fade_bus.duty_g), 0);
    tick(1);
    check("t1_g24", int'(fade_bus.duty_g), 4);
    check("t1_r24", int'(fade_bus.duty_r), 12);
    check("t1_b24", int'(fade_bus.duty_b), 0);
    tick(24);
    check("t1_g48", int'(fade_bus.duty_g), 8);
    tick(23);
    check("t1_phase71", int'(fade_bus.phase), 0);
    check("t1_pdone71", int'(fade_bus.phase_done), 0);
    tick(1);
    check("t1_g72", int'(fade_bus.duty_g), 12);
    check("t1_phase72", int'(fade_bus.phase), 1);
    check("t1_pdone72", int'(fade_bus.phase_done), 1);

    // 2: rest of the wheel, with bound and glitch tracking
    pulses   = 1;
    glitches = 0;
    overs    = 0;
    pr = int'(fade_bus.duty_r);
    pg = int'(fade_bus.duty_g);
    pb = int'(fade_bus.duty_b);
    for (int c = 73; c <= 432; c++) begin
      tick(1);
      if (fade_bus.phase_done) pulses++;
      if (fade_bus.duty_r > 4'd12 || fade_bus.duty_g > 4'd12 || fade_bus.duty_b > 4'd12) overs++;
      if ((int'(fade_bus.duty_r) != pr || int'(fade_bus.duty_g) != pg ||
           int'(fade_bus.duty_b) != pb) && fade_bus.pwm_cnt != 4'd0) glitches++;
      pr = int'(fade_bus.duty_r);
      pg = int'(fade_bus.duty_g);
      pb = int'(fade_bus.duty_b);
      if (c == 73) check("t2_pdone73", int'(fade_bus.phase_done), 0);
    end
    check("t2_phase", int'(fade_bus.phase), 0);
    check("t2_r", int'(fade_bus.duty_r), 12);
    check("t2_g", int'(fade_bus.duty_g), 0);
    check("t2_b", int'(fade_bus.duty_b), 0);
    check("t2_pulses", pulses, 6);
    check("t2_overs", overs, 0);
    check("t6_glitches", glitches, 0);

    // 3: hold during cycles 20..60
    do_reset();
    tick(20);
    fade_bus.hold = 1'b1;
    tick(40);
    check("t3_g60", int'(fade_bus.duty_g), 0);
    check("t3_pwm60", int'(fade_bus.pwm_cnt), 0);
    tick(1);
    fade_bus.hold = 1'b0;
    tick(10);
    check("t3_pend71", int'(fade_bus.period_end), 1);
    check("t3_g71", int'(fade_bus.duty_g), 0);
    tick(1);
    check("t3_g72", int'(fade_bus.duty_g), 4);

    // 4: en low for 30 cycles at pwm_cnt=5
    do_reset();
    tick(5);
    fade_bus.en = 1'b0;
    tick(30);
    check("t4_pwm_frz", int'(fade_bus.pwm_cnt), 5);
    check("t4_pend_frz", int'(fade_bus.period_end), 0);
    check("t4_r_frz", int'(fade_bus.duty_r), 12);
    fade_bus.en = 1'b1;
    tick(1);
    check("t4_pwm_res", int'(fade_bus.pwm_cnt), 6);
    tick(17);
    check("t4_g53", int'(fade_bus.duty_g), 0);
    tick(1);
    check("t4_g54", int'(fade_bus.duty_g), 4);
    tick(11);
    check("t4_pend_on", int'(fade_bus.period_end), 1);
    fade_bus.en = 1'b0;
    #1;
    check("t4_pend_off", int'(fade_bus.period_end), 0);
    fade_bus.en = 1'b1;

    // 5: reset mid phase 3 with en low and hold high
    do_reset();
    tick(246);
    check("t5_phase", int'(fade_bus.phase), 3);
    check("t5_g", int'(fade_bus.duty_g), 8);
    check("t5_b", int'(fade_bus.duty_b), 12);
    check("t5_r", int'(fade_bus.duty_r), 0);
    rst = 1'b1;
    fade_bus.en   = 1'b0;
    fade_bus.hold = 1'b1;
    tick(1);
    check_reset_state("t5_rst");
    rst = 1'b0;
    fade_bus.hold = 1'b0;
    fade_bus.en   = 1'b1;
    tick(1);
    check("t5_pwm_after", int'(fade_bus.pwm_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
